// File: rtl/eq_match_pkg.sv
// Shared types and default parameters for the equality match counter.
// Provides the counting-mode enum used by the channel datapath.
package eq_match_pkg;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } cnt_mode_e;

    localparam int unsigned DEF_NCH      = 4;
    localparam int unsigned DEF_HALF_W   = 2;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam bit          DEF_SATURATE = 1'b1;

endpackage

// File: rtl/eq_match_channel.sv
// One channel: half-field comparator, counter, prev/match history,
// sticky hit and ovf flags.
// Ports: clk, rst_n, valid_i, field_i, mode_i, clr_i, thresh_i,
//        cnt_o, match_o, hit_o, ovf_o.
module eq_match_channel
    import eq_match_pkg::*;
#(
    parameter int unsigned HALF_W   = DEF_HALF_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter bit          SATURATE = DEF_SATURATE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [2*HALF_W-1:0]   field_i,
    input  logic                  mode_i,
    input  logic                  clr_i,
    input  logic [CNT_W-1:0]      thresh_i,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  match_o,
    output logic                  hit_o,
    output logic                  ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             prev_q, prev_d;
    logic             match_q, match_d;
    logic             hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             eq, inc, at_max;
    cnt_mode_e        mode;

    assign mode   = cnt_mode_e'(mode_i);
    assign eq     = (field_i[2*HALF_W-1:HALF_W] == field_i[HALF_W-1:0]);
    assign at_max = (cnt_q == {CNT_W{1'b1}});

    // Edge mode only counts the rising edge of equality across valid samples.
    assign inc = valid_i && eq && ((mode == LEVEL) || !prev_q);

    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        if (at_max) begin
            cnt_inc = SATURATE ? cnt_q : '0;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        match_d = match_q;
        hit_d   = hit_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            cnt_d   = '0;
            prev_d  = 1'b0;
            match_d = 1'b0;
            hit_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (valid_i) begin
            prev_d  = eq;
            match_d = eq;
            if (inc) begin
                cnt_d = cnt_inc;
                if (at_max) begin
                    ovf_d = 1'b1;
                end
                if ((thresh_i != '0) && (cnt_inc == thresh_i)) begin
                    hit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            match_q <= 1'b0;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            match_q <= match_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign match_o = match_q;
    assign hit_o   = hit_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/eq_match_counter.sv
// Multi-channel equality counter: slices in_data into NCH fields and
// packs per-channel count/match/hit/ovf. Ports: clk, rst_n, in_valid,
// in_data, mode, clr, thresh, equal_cnt, match, hit, ovf.
module eq_match_counter
    import eq_match_pkg::*;
#(
    parameter int unsigned NCH      = DEF_NCH,
    parameter int unsigned HALF_W   = DEF_HALF_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter bit          SATURATE = DEF_SATURATE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [NCH*2*HALF_W-1:0] in_data,
    input  logic                    mode,
    input  logic                    clr,
    input  logic [CNT_W-1:0]        thresh,
    output logic [NCH*CNT_W-1:0]    equal_cnt,
    output logic [NCH-1:0]          match,
    output logic [NCH-1:0]          hit,
    output logic [NCH-1:0]          ovf
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        eq_match_channel #(
            .HALF_W   (HALF_W),
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_i  (in_valid),
            .field_i  (in_data[c*2*HALF_W +: 2*HALF_W]),
            .mode_i   (mode),
            .clr_i    (clr),
            .thresh_i (thresh),
            .cnt_o    (equal_cnt[c*CNT_W +: CNT_W]),
            .match_o  (match[c]),
            .hit_o    (hit[c]),
            .ovf_o    (ovf[c])
        );
    end

endmodule

// File: tb/tb_eq_match_counter.sv
// Directed self-checking bench for eq_match_counter.
// Default 4-channel instance plus two 1-channel CNT_W=4 instances.
module tb_eq_match_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        mode;
    logic        clr;
    logic [7:0]  thresh;
    logic [31:0] equal_cnt;
    logic [3:0]  match, hit, ovf;

    logic [3:0]  in_data_s;
    logic [3:0]  thresh_s;
    logic [3:0]  cnt_sat, cnt_wrp;
    logic        match_sat, hit_sat, ovf_sat;
    logic        match_wrp, hit_wrp, ovf_wrp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eq_match_counter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data(in_data), .mode(mode), .clr(clr), .thresh(thresh),
        .equal_cnt(equal_cnt), .match(match), .hit(hit), .ovf(ovf)
    );

    eq_match_counter #(.NCH(1), .HALF_W(2), .CNT_W(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data(in_data_s), .mode(mode), .clr(clr), .thresh(thresh_s),
        .equal_cnt(cnt_sat), .match(match_sat), .hit(hit_sat), .ovf(ovf_sat)
    );

    eq_match_counter #(.NCH(1), .HALF_W(2), .CNT_W(4), .SATURATE(0)) dut_wrp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data(in_data_s), .mode(mode), .clr(clr), .thresh(thresh_s),
        .equal_cnt(cnt_wrp), .match(match_wrp), .hit(hit_wrp), .ovf(ovf_wrp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        in_data_s = 4'hF;
        mode = 1'b0;
        clr = 1'b0;
        thresh = 8'd0;
        thresh_s = 4'd0;
        tick();
        tick();
        checks++;
        if ({equal_cnt, match, hit, ovf} !== 44'd0) begin
            $display("FAIL reset_during cnt=%h m=%b h=%b o=%b exp 0",
                     equal_cnt, match, hit, ovf);
            errors++;
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({equal_cnt, match, hit, ovf} !== 44'd0) begin
            $display("FAIL reset_after cnt=%h m=%b h=%b o=%b exp 0",
                     equal_cnt, match, hit, ovf);
            errors++;
        end
        checks++;
        if ({cnt_sat, cnt_wrp, ovf_sat, ovf_wrp} !== 10'd0) begin
            $display("FAIL reset_small sat=%0d wrp=%0d exp 0", cnt_sat, cnt_wrp);
            errors++;
        end
    endtask

    task automatic test_level();
        do_clr();
        mode = 1'b0;
        in_data = {4'b0001, 4'b0001, 4'b1001, 4'b1010};
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        checks++;
        if (equal_cnt[7:0] !== 8'd5) begin
            $display("FAIL level_cnt0 got %0d exp 5", equal_cnt[7:0]);
            errors++;
        end
        checks++;
        if (equal_cnt[15:8] !== 8'd0) begin
            $display("FAIL level_cnt1 got %0d exp 0", equal_cnt[15:8]);
            errors++;
        end
        checks++;
        if (match !== 4'b0001) begin
            $display("FAIL level_match got %b exp 0001", match);
            errors++;
        end
    endtask

    task automatic test_edge();
        logic [3:0] seq [5];
        seq = '{4'b1010, 4'b1010, 4'b1001, 4'b0101, 4'b0101};
        do_clr();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = {12'h111, seq[i]};
            in_valid = 1'b1;
            tick();
        end
        checks++;
        if (equal_cnt[7:0] !== 8'd2) begin
            $display("FAIL edge_cnt got %0d exp 2", equal_cnt[7:0]);
            errors++;
        end
        in_valid = 1'b0;
        in_data = {12'h111, 4'b0000};
        repeat (3) tick();
        checks++;
        if (equal_cnt[7:0] !== 8'd2 || match[0] !== 1'b1) begin
            $display("FAIL edge_idle cnt=%0d m=%b exp 2/1",
                     equal_cnt[7:0], match[0]);
            errors++;
        end
        in_data = {12'h111, 4'b0101};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (equal_cnt[7:0] !== 8'd2) begin
            $display("FAIL edge_prev_hold got %0d exp 2", equal_cnt[7:0]);
            errors++;
        end
    endtask

    task automatic test_overflow();
        do_clr();
        mode = 1'b0;
        in_data_s = 4'b1111;
        in_valid = 1'b1;
        repeat (15) tick();
        checks++;
        if (cnt_sat !== 4'd15 || ovf_sat !== 1'b0 ||
            cnt_wrp !== 4'd15 || ovf_wrp !== 1'b0) begin
            $display("FAIL ovf_at_max sat=%0d/%b wrp=%0d/%b exp 15/0",
                     cnt_sat, ovf_sat, cnt_wrp, ovf_wrp);
            errors++;
        end
        repeat (5) tick();
        in_valid = 1'b0;
        checks++;
        if (cnt_sat !== 4'd15 || ovf_sat !== 1'b1) begin
            $display("FAIL saturate cnt=%0d ovf=%b exp 15/1", cnt_sat, ovf_sat);
            errors++;
        end
        checks++;
        if (cnt_wrp !== 4'd4 || ovf_wrp !== 1'b1) begin
            $display("FAIL wrap cnt=%0d ovf=%b exp 4/1", cnt_wrp, ovf_wrp);
            errors++;
        end
    endtask

    task automatic test_thresh();
        do_clr();
        mode = 1'b0;
        thresh = 8'd3;
        in_data = {12'h111, 4'b1111};
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (hit[0] !== 1'b0) begin
            $display("FAIL hit_early got %b exp 0", hit[0]);
            errors++;
        end
        tick();
        checks++;
        if (hit !== 4'b0001) begin
            $display("FAIL hit_rise got %b exp 0001", hit);
            errors++;
        end
        tick();
        in_valid = 1'b0;
        thresh = 8'd0;
        tick();
        checks++;
        if (hit[0] !== 1'b1 || equal_cnt[7:0] !== 8'd4) begin
            $display("FAIL hit_sticky h=%b cnt=%0d exp 1/4",
                     hit[0], equal_cnt[7:0]);
            errors++;
        end
    endtask

    task automatic test_clr_priority();
        in_valid = 1'b1;
        in_data = 16'hFFFF;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({equal_cnt, match, hit, ovf} !== 44'd0) begin
            $display("FAIL clr_prio cnt=%h m=%b h=%b o=%b exp 0",
                     equal_cnt, match, hit, ovf);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        do_clr();
        mode = 1'b0;
        in_data = {12'h111, 4'b0000};
        in_valid = 1'b1;
        repeat (7) tick();
        checks++;
        if (equal_cnt[7:0] !== 8'd7) begin
            $display("FAIL pre_reset_cnt got %0d exp 7", equal_cnt[7:0]);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (equal_cnt !== 32'd0 || match !== 4'd0) begin
            $display("FAIL async_reset cnt=%h m=%b exp 0", equal_cnt, match);
            errors++;
        end
        #1;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (equal_cnt[7:0] !== 8'd1) begin
            $display("FAIL resume_cnt got %0d exp 1", equal_cnt[7:0]);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_overflow();
        test_thresh();
        test_clr_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
